// File: rtl/mem_responder.sv
// Memory-side responder for the CPU bus: synchronous RAM plus a four-word I/O window.
// Read data is registered and appears one cycle after the read strobe.
module mem_responder #(
  parameter int unsigned RAM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [29:0] memaddr,
  input  logic [31:0] wmemdata,
  output logic [31:0] rmemdata,
  output logic [31:0] io_out,
  output logic        io_out_valid,
  input  logic [31:0] io_in
);

  localparam int unsigned RamDepth = 1 << RAM_AW;

  logic [31:0]       ram [RamDepth];
  logic              rd, wr, sel_io;
  logic [1:0]        io_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       io_rdata;

  logic [31:0] rmemdata_q, io_out_q, cycle_q, access_q, sync1_q, sync2_q;
  logic        io_out_valid_q;

  // Upper address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^memaddr;

  // A read strobe always wins; a simultaneous write is dropped.
  assign rd      = mem_re;
  assign wr      = mem_we & ~mem_re;
  assign sel_io  = memaddr[29];
  assign io_idx  = memaddr[1:0];
  assign ram_idx = memaddr[RAM_AW-1:0];

  always_comb begin
    io_rdata = '0;
    unique case (io_idx)
      2'd0: io_rdata = cycle_q;
      2'd1: io_rdata = io_out_q;
      2'd2: io_rdata = sync2_q;
      2'd3: io_rdata = access_q;
      default: io_rdata = '0;
    endcase
  end

  // RAM contents are deliberately not reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr && !sel_io) begin
      ram[ram_idx] <= wmemdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rmemdata_q     <= '0;
      io_out_q       <= '0;
      io_out_valid_q <= 1'b0;
      cycle_q        <= '0;
      access_q       <= '0;
      sync1_q        <= '0;
      sync2_q        <= '0;
    end else begin
      cycle_q        <= cycle_q + 32'd1;
      sync1_q        <= io_in;
      sync2_q        <= sync1_q;
      io_out_valid_q <= 1'b0;
      if (rd) begin
        rmemdata_q <= sel_io ? io_rdata : ram[ram_idx];
      end
      if (wr && sel_io && io_idx == 2'd1) begin
        io_out_q       <= wmemdata;
        io_out_valid_q <= 1'b1;
      end
      // Clearing write is not itself counted.
      if (wr && sel_io && io_idx == 2'd3) begin
        access_q <= '0;
      end else if (rd || wr) begin
        access_q <= access_q + 32'd1;
      end
    end
  end

  assign rmemdata     = rmemdata_q;
  assign io_out       = io_out_q;
  assign io_out_valid = io_out_valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: expected read data is queued when a read is issued
// and checked against rmemdata after the capturing edge.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re, mem_we;
  logic [29:0] memaddr;
  logic [31:0] wmemdata, rmemdata, io_out, io_in;
  logic        io_out_valid;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  mem_responder #(.RAM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .memaddr     (memaddr),
    .wmemdata    (wmemdata),
    .rmemdata    (rmemdata),
    .io_out      (io_out),
    .io_out_valid(io_out_valid),
    .io_in       (io_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    memaddr = 'x;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", rmemdata);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, rmemdata, e);
    end
  endtask

  task automatic rd(input string tag, input logic [29:0] a, input logic [31:0] exp,
                    input logic also_we = 1'b0, input logic [31:0] wd = '0);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    mem_re   = 1'b1;
    mem_we   = also_we;
    memaddr  = a;
    wmemdata = wd;
    step();
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    memaddr = 'x;
    pop_check();
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    mem_re   = 1'b0;
    mem_we   = 1'b1;
    memaddr  = a;
    wmemdata = d;
    step();
    mem_we  = 1'b0;
    memaddr = 'x;
  endtask

  initial begin
    rst = 1'b1; mem_re = 1'b0; mem_we = 1'b0; memaddr = 'x; wmemdata = '0; io_in = '0;
    step();
    step();
    check("reset_rmemdata", rmemdata, 32'h0);
    check("reset_io_out", io_out, 32'h0);
    check("reset_io_out_valid", {31'b0, io_out_valid}, 32'h0);
    rst = 1'b0;

    // cycle_count read at the 10th active edge returns 9.
    idle(9);
    rd("cycle_count_edge10", 30'h2000_0000, 32'd9);

    // RAM write/read and hold.
    wr(30'h5, 32'hDEAD_BEEF);
    rd("ram_raw", 30'h5, 32'hDEAD_BEEF);
    idle(3);
    check("ram_hold", rmemdata, 32'hDEAD_BEEF);

    // Aliasing and dual strobe.
    wr(30'h400, 32'h1234);
    rd("ram_alias", 30'h0, 32'h1234);
    rd("dual_strobe", 30'h0, 32'h1234, 1'b1, 32'hFFFF);
    rd("dual_no_write", 30'h0, 32'h1234);

    // io_out write, pulse and readback.
    wr(30'h2000_0001, 32'hA5);
    check("io_out_value", io_out, 32'hA5);
    check("io_out_valid_pulse", {31'b0, io_out_valid}, 32'h1);
    idle(1);
    check("io_out_valid_drop", {31'b0, io_out_valid}, 32'h0);
    rd("io_out_read", 30'h2000_0001, 32'hA5);
    wr(30'h2FFF_FFF5, 32'h11);
    check("b2b_valid_1", {31'b0, io_out_valid}, 32'h1);
    wr(30'h2000_0001, 32'h22);
    check("b2b_valid_2", {31'b0, io_out_valid}, 32'h1);
    check("b2b_io_out", io_out, 32'h22);

    // access_count: clear, three accesses, read, clear then read.
    wr(30'h2000_0003, 32'hFFFF_FFFF);
    wr(30'h10, 32'h7);
    rd("ram_0x10", 30'h10, 32'h7);
    wr(30'h2000_0000, 32'h5);
    rd("access_count_3", 30'h2000_0003, 32'd3);
    wr(30'h2000_0003, 32'h0);
    rd("access_count_clear", 30'h2000_0003, 32'd0);

    // io_in synchroniser latency.
    io_in = 32'h77;
    idle(1);
    rd("io_in_old", 30'h2000_0002, 32'h0);
    rd("io_in_new", 30'h2000_0002, 32'h77);
    wr(30'h2000_0002, 32'h5);
    rd("io_in_ro", 30'h2000_0002, 32'h77);

    // Reset wins over same-edge writes, including to RAM.
    rst = 1'b1;
    wr(30'h2000_0001, 32'h99);
    check("rst_io_out", io_out, 32'h0);
    check("rst_io_out_valid", {31'b0, io_out_valid}, 32'h0);
    check("rst_rmemdata", rmemdata, 32'h0);
    wr(30'h5, 32'h55);
    rst = 1'b0;
    rd("rst_access_count", 30'h2000_0003, 32'd0);
    rd("rst_ram_write_blocked", 30'h5, 32'hDEAD_BEEF);
    rd("rst_cycle_count", 30'h2000_0000, 32'd2);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU memory bus. It serves the CPU's word-addressed read/write strobes from on-chip synchronous RAM and a small memory-mapped I/O window. It returns registered read data one cycle after each read strobe, which is the capture point the CPU's fetch and load states rely on. It sits directly on the CPU's `mem_re`/`mem_we`/`memaddr`/`rmemdata`/`wmemdata` pins at the top level.

## Interface
- `RAM_AW`, default 10: log2 of RAM depth in 32-bit words (1024 words).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high; clock `clk`.
- `mem_re`  in  1  read strobe for the current cycle.
- `mem_we`  in  1  write strobe for the current cycle.
- `memaddr`  in  30  word address; don't-care (may be X/Z) when both strobes are low.
- `wmemdata`  in  32  write data; valid only when `mem_we && !mem_re`.
- `rmemdata`  out  32  registered read data.
- `io_out`  out  32  output port register (I/O word 1).
- `io_out_valid`  out  1  one-cycle pulse after each write to I/O word 1.
- `io_in`  in  32  asynchronous input port; synchronised internally.

## Operation
- **Address decode:**
  - `memaddr[29]==0` selects RAM, indexed by `memaddr[RAM_AW-1:0]`. Upper bits are ignored, so RAM aliases across the region.
  - `memaddr[29]==1` selects I/O, indexed by `memaddr[1:0]`; bits [28:2] are ignored (aliased).
- **I/O map:**
  - Word 0, `cycle_count`, read-only: increments every non-reset cycle and wraps at 2^32.
  - Word 1, `io_out`, read/write: a write loads the register and pulses `io_out_valid`; a read returns the current value.
  - Word 2, `io_in`, read-only: value from a 2-flop synchroniser.
  - Word 3, `access_count`, read-only: counts accepted reads plus writes and wraps at 2^32. A write to word 3 clears it to 0, and that write is not itself counted.
  - Writes to words 0 and 2 are ignored; they are still counted.
- **Strobe rules:**
  - `mem_re=1`: read the selected location; the result goes to `rmemdata` at the edge.
  - `mem_we=1, mem_re=0`: write `wmemdata` to the selected location at the edge.
  - Both high: treat as a read only; write suppressed.
  - Both low: no access. `rmemdata` holds its previous value, and no state other than the counters and synchroniser changes.
- **RAM:** contents are not reset. A read of a never-written word returns X in simulation.
- **Reset values:** `rmemdata`, `io_out`, `cycle_count`, `access_count` and the synchroniser flops = 0; `io_out_valid` = 0.

## Timing
- **Read latency:** exactly 1 cycle. Strobe and address present before edge k → `rmemdata` valid after edge k and held until the next read edge.
- **Write:** commits at the edge where it is presented.
- **Read-after-write, same address, at edge k+1:** returns the data written at edge k; no stale data.
- **`cycle_count` read at edge k:** returns the pre-increment value at edge k. After reset deassert, the first read at the first active edge returns 0.
- **`access_count` read:** returns the count excluding the read itself.
- **`io_out_valid`:** high for exactly the one cycle after the write edge. Back-to-back writes keep it high with `io_out` updating each cycle.
- **`io_in`:** a change is visible to reads sampled 2 edges after it is stable at the input.
- **Reset asserted mid-operation:** reset wins over any same-edge access. The RAM write at that edge is suppressed, and all registers take their reset values.

## Test plan
- **RAM write then read:** write 0xDEADBEEF to addr 0x5 (edge 1), read addr 0x5 (edge 2) → `rmemdata`=0xDEADBEEF after edge 2, held through 3 idle cycles.
- **Aliasing and dual strobe:**
  - Write 0x1234 to addr 0x400 with `RAM_AW`=10, then read addr 0x0 → 0x1234.
  - Assert re+we with `wmemdata`=0xFFFF to addr 0x0 → reads 0x1234, and a later read still returns 0x1234.
- **`io_out`:** write 0xA5 to addr 0x20000001 → `io_out`=0xA5 and `io_out_valid`=1 for one cycle only. A read of the same address returns 0xA5.
- **Counters:**
  - Reset, then read addr 0x20000000 at the 10th active edge → 9.
  - Perform 3 accesses, then read addr 0x20000003 → 3.
  - Write to addr 0x20000003, then read it → 0.
- **`io_in` sync:** set `io_in`=0x77 before edge n; a read of addr 0x20000002 at edge n+1 returns the old value and at edge n+2 returns 0x77.
- **Reset mid-write:** assert `rst` with a write of 0x99 to `io_out` → `io_out`=0, `io_out_valid`=0, and a subsequent `access_count` read returns 0.
